// File: rtl/ram_arbiter_2ch.sv
// Two-client round-robin arbiter in front of a single-port RAM with registered Q.
// Grants are combinational, RAM commands are registered, and read data returns two cycles after the grant.
module ram_arbiter_2ch #(
  parameter int ADD_WIDTH  = 7,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Req0,
  input  logic                  We0,
  input  logic [ADD_WIDTH-1:0]  Add0,
  input  logic [DATA_WIDTH-1:0] Data0,
  output logic                  Gnt0,
  output logic                  Rvalid0,
  output logic [DATA_WIDTH-1:0] Rdata0,
  input  logic                  Req1,
  input  logic                  We1,
  input  logic [ADD_WIDTH-1:0]  Add1,
  input  logic [DATA_WIDTH-1:0] Data1,
  output logic                  Gnt1,
  output logic                  Rvalid1,
  output logic [DATA_WIDTH-1:0] Rdata1,
  output logic                  Ram_we,
  output logic [ADD_WIDTH-1:0]  Ram_add,
  output logic [DATA_WIDTH-1:0] Ram_data,
  input  logic [DATA_WIDTH-1:0] Ram_q
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state_reg, state_next;
  logic            last_reg, last_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [CW-1:0]   cnt_inc;
  logic            gnt0_c, gnt1_c;

  logic                  ram_we_reg;
  logic [ADD_WIDTH-1:0]  ram_add_reg;
  logic [DATA_WIDTH-1:0] ram_data_reg;
  logic                  vld1_reg, vld2_reg;
  logic                  tag1_reg, tag2_reg;

  logic                  xfer;
  logic                  win_we;
  logic [ADD_WIDTH-1:0]  win_add;
  logic [DATA_WIDTH-1:0] win_data;

  logic [1:0]            rvalid;
  logic [DATA_WIDTH-1:0] rdata [2];

  assign cnt_inc = (cnt_reg == MAX_CNT) ? MAX_CNT : cnt_reg + ONE_CNT;

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    gnt0_c     = 1'b0;
    gnt1_c     = 1'b0;
    case (state_reg)
      IDLE: begin
        // On contention the client not served last wins.
        if (Req0 && (!Req1 || last_reg)) begin
          gnt0_c     = 1'b1;
          state_next = OWN0;
          cnt_next   = ONE_CNT;
        end else if (Req1) begin
          gnt1_c     = 1'b1;
          state_next = OWN1;
          cnt_next   = ONE_CNT;
        end
      end
      OWN0: begin
        if (Req0 && (!Req1 || cnt_reg < MAX_CNT)) begin
          gnt0_c   = 1'b1;
          cnt_next = cnt_inc;
        end else if (Req1) begin
          gnt1_c     = 1'b1;
          state_next = OWN1;
          cnt_next   = ONE_CNT;
          last_next  = 1'b0;
        end else begin
          state_next = IDLE;
          last_next  = 1'b0;
        end
      end
      OWN1: begin
        if (Req1 && (!Req0 || cnt_reg < MAX_CNT)) begin
          gnt1_c   = 1'b1;
          cnt_next = cnt_inc;
        end else if (Req0) begin
          gnt0_c     = 1'b1;
          state_next = OWN0;
          cnt_next   = ONE_CNT;
          last_next  = 1'b1;
        end else begin
          state_next = IDLE;
          last_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign Gnt0 = gnt0_c & Rst_n;
  assign Gnt1 = gnt1_c & Rst_n;

  assign xfer     = Gnt0 | Gnt1;
  assign win_we   = Gnt1 ? We1   : We0;
  assign win_add  = Gnt1 ? Add1  : Add0;
  assign win_data = Gnt1 ? Data1 : Data0;

  // Tag pipeline aligns with the RAM's command register plus its registered Q.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ram_we_reg   <= 1'b0;
      ram_add_reg  <= '0;
      ram_data_reg <= '0;
      vld1_reg     <= 1'b0;
      vld2_reg     <= 1'b0;
      tag1_reg     <= 1'b0;
      tag2_reg     <= 1'b0;
    end else begin
      ram_we_reg <= xfer & win_we;
      if (xfer) begin
        ram_add_reg  <= win_add;
        ram_data_reg <= win_data;
      end
      vld1_reg <= xfer & ~win_we;
      tag1_reg <= Gnt1;
      vld2_reg <= vld1_reg;
      tag2_reg <= tag1_reg;
    end
  end

  assign Ram_we   = ram_we_reg;
  assign Ram_add  = ram_add_reg;
  assign Ram_data = ram_data_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      logic [DATA_WIDTH-1:0] hold_reg;
      assign rvalid[gi] = vld2_reg && (tag2_reg == 1'(gi));
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)          hold_reg <= '0;
        else if (rvalid[gi]) hold_reg <= Ram_q;
      end
      assign rdata[gi] = rvalid[gi] ? Ram_q : hold_reg;
    end
  endgenerate

  assign Rvalid0 = rvalid[0];
  assign Rvalid1 = rvalid[1];
  assign Rdata0  = rdata[0];
  assign Rdata1  = rdata[1];

endmodule

// File: tb/tb_ram_arbiter_2ch.sv
// Scoreboard bench for ram_arbiter_2ch: per-client command queues, a behavioural RAM,
// a shadow memory giving expected read data, and grant-pattern logs for the arbitration cases.
module tb_ram_arbiter_2ch;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b1;
  logic          Req0 = 1'b0, We0 = 1'b0, Req1 = 1'b0, We1 = 1'b0;
  logic [AW-1:0] Add0 = '0, Add1 = '0;
  logic [DW-1:0] Data0 = '0, Data1 = '0;
  logic          Gnt0, Gnt1, Rvalid0, Rvalid1, Ram_we;
  logic [DW-1:0] Rdata0, Rdata1, Ram_data;
  logic [AW-1:0] Ram_add;
  logic [DW-1:0] ram_q;

  ram_arbiter_2ch #(.ADD_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Req0(Req0), .We0(We0), .Add0(Add0), .Data0(Data0),
    .Gnt0(Gnt0), .Rvalid0(Rvalid0), .Rdata0(Rdata0),
    .Req1(Req1), .We1(We1), .Add1(Add1), .Data1(Data1),
    .Gnt1(Gnt1), .Rvalid1(Rvalid1), .Rdata1(Rdata1),
    .Ram_we(Ram_we), .Ram_add(Ram_add), .Ram_data(Ram_data), .Ram_q(ram_q)
  );

  initial forever #5 Clk = ~Clk;

  logic [DW-1:0] mem [128];
  always @(posedge Clk) begin
    if (Ram_we) mem[Ram_add] <= Ram_data;
    ram_q <= mem[Ram_add];
  end

  typedef struct packed {logic we; logic [AW-1:0] add; logic [DW-1:0] data;} cmd_t;
  typedef struct {logic ch; logic [DW-1:0] data; int cyc;} exp_t;

  cmd_t          q0[$], q1[$];
  exp_t          sb[$];
  int            glog[$];
  logic [DW-1:0] shadow [128];
  int            n_cmp = 0, n_bad = 0;
  int            cyc = 0;
  bit            xfer0 = 0, xfer1 = 0, log_en = 0;
  bit            prev_v = 0;
  cmd_t          prev_cmd;
  logic [DW-1:0] last_rd0 = '0, last_rd1 = '0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_return(input logic ch, input logic [DW-1:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      check_value($sformatf("rvalid%0d_unexpected", ch), sb.size(), 1);
    end else begin
      e = sb.pop_front();
      check_value("rvalid_channel", ch, e.ch);
      check_value($sformatf("rdata%0d", ch), data, e.data);
      check_value("rvalid_latency", cyc, e.cyc);
      $display("read return ch%0d data=%0h cycle=%0d", ch, data, cyc);
    end
  endtask

  initial forever #1 begin end

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
  end

  initial forever @(posedge Clk) cyc++;

  // Monitor: sampled on the falling edge, mid-cycle.
  initial forever begin
    @(negedge Clk);
    if (!Rst_n) begin
      prev_v   = 0;
      xfer0    = 0;
      xfer1    = 0;
      last_rd0 = '0;
      last_rd1 = '0;
      sb.delete();
    end else begin
      if (prev_v) begin
        check_value("ram_we", Ram_we, prev_cmd.we);
        check_value("ram_add", Ram_add, prev_cmd.add);
        if (prev_cmd.we) check_value("ram_data", Ram_data, prev_cmd.data);
      end else begin
        check_value("ram_we_idle", Ram_we, 0);
      end
      check_value("gnt_both", Gnt0 & Gnt1, 0);
      if (Rvalid0) check_return(1'b0, Rdata0);
      else         check_value("rdata0_hold", Rdata0, last_rd0);
      if (Rvalid1) check_return(1'b1, Rdata1);
      else         check_value("rdata1_hold", Rdata1, last_rd1);
      if (Rvalid0) last_rd0 = Rdata0;
      if (Rvalid1) last_rd1 = Rdata1;
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        check_value("rvalid_late", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      xfer0  = Req0 && Gnt0;
      xfer1  = Req1 && Gnt1;
      prev_v = xfer0 || xfer1;
      if (prev_v) begin
        prev_cmd = xfer1 ? cmd_t'{We1, Add1, Data1} : cmd_t'{We0, Add0, Data0};
        $display("grant ch%0d we=%0d add=%0d data=%0h cycle=%0d",
                 xfer1, prev_cmd.we, prev_cmd.add, prev_cmd.data, cyc);
        if (prev_cmd.we) shadow[prev_cmd.add] = prev_cmd.data;
        else sb.push_back('{ch: xfer1, data: shadow[prev_cmd.add], cyc: cyc + 2});
      end
      if (log_en) glog.push_back({30'd0, Gnt1, Gnt0});
    end
  end

  task automatic apply_req();
    if (q0.size() > 0) begin
      Req0 = 1'b1; We0 = q0[0].we; Add0 = q0[0].add; Data0 = q0[0].data;
    end else Req0 = 1'b0;
    if (q1.size() > 0) begin
      Req1 = 1'b1; We1 = q1[0].we; Add1 = q1[0].add; Data1 = q1[0].data;
    end else Req1 = 1'b0;
  endtask

  task automatic drive_cycle();
    @(posedge Clk);
    #1;
    if (xfer0 && q0.size() > 0) void'(q0.pop_front());
    if (xfer1 && q1.size() > 0) void'(q1.pop_front());
    apply_req();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    do begin
      drive_cycle();
      n++;
    end while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || Req0 || Req1) && n < budget);
    if (n >= budget) check_value("drain_timeout", n, 0);
    drive_cycle();
    drive_cycle();
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_value({pfx, "_gnt0"}, Gnt0, 0);
    check_value({pfx, "_gnt1"}, Gnt1, 0);
    check_value({pfx, "_ram_we"}, Ram_we, 0);
    check_value({pfx, "_ram_add"}, Ram_add, 0);
    check_value({pfx, "_ram_data"}, Ram_data, 0);
    check_value({pfx, "_rvalid0"}, Rvalid0, 0);
    check_value({pfx, "_rvalid1"}, Rvalid1, 0);
    check_value({pfx, "_rdata0"}, Rdata0, 0);
    check_value({pfx, "_rdata1"}, Rdata1, 0);
  endtask

  task automatic reset_pulse(input string pfx);
    Rst_n = 1'b0;
    #1;
    check_outputs_zero(pfx);
    @(negedge Clk);
    #2;
    Rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both clients requesting: grants must stay low.
    Req0 = 1'b1; Req1 = 1'b1;
    #1 Rst_n = 1'b0;
    #2 check_outputs_zero("rst0");
    Req0 = 1'b0; Req1 = 1'b0;
    @(negedge Clk);
    #2 Rst_n = 1'b1;

    // Back-to-back writes from client 0.
    q0.push_back('{1'b1, 7'd0, 32'd1});
    q0.push_back('{1'b1, 7'd10, 32'd10});
    q0.push_back('{1'b1, 7'd20, 32'd220});
    glog.delete();
    drive_cycle();
    log_en = 1;
    run_until_idle(50);
    log_en = 0;
    for (int i = 0; i < 3; i++) check_value($sformatf("a_gnt%0d", i), glog[i], 1);
    check_value("a_gnt_after", glog[3], 0);

    // Consecutive reads of the values just written.
    q0.push_back('{1'b0, 7'd0, 32'd0});
    q0.push_back('{1'b0, 7'd10, 32'd0});
    q0.push_back('{1'b0, 7'd20, 32'd0});
    run_until_idle(50);
    check_value("b_rdata0_last", Rdata0, 32'd220);

    // Continuous contention from a fresh reset.
    @(posedge Clk);
    #2 reset_pulse("rst1");
    for (int i = 0; i < 12; i++) begin
      q0.push_back('{1'b0, AW'(i), 32'd0});
      q1.push_back('{1'b0, AW'(64 + i), 32'd0});
    end
    glog.delete();
    drive_cycle();
    log_en = 1;
    run_until_idle(100);
    log_en = 0;
    for (int i = 0; i < 24; i++)
      check_value($sformatf("c_gnt%0d", i), glog[i], ((i / MB) % 2 == 0) ? 1 : 2);
    check_value("c_gnt_after", glog[24], 0);

    // Cross-client write then read of the same address.
    q1.push_back('{1'b1, 7'd127, 32'hFFFFFFFF});
    drive_cycle();
    q0.push_back('{1'b0, 7'd127, 32'd0});
    run_until_idle(50);
    check_value("d_rdata0", Rdata0, 32'hFFFFFFFF);
    check_value("d_rdata1", Rdata1, 0);

    // Read in flight killed by an asynchronous mid-cycle reset.
    q0.push_back('{1'b1, 7'd100, 32'hFFAC0780});
    run_until_idle(50);
    q0.push_back('{1'b0, 7'd100, 32'd0});
    drive_cycle();
    drive_cycle();
    check_value("e_read_issued", q0.size(), 0);
    #1 reset_pulse("rst2");
    repeat (6) drive_cycle();
    q0.push_back('{1'b0, 7'd100, 32'd0});
    run_until_idle(50);
    check_value("e_reread", Rdata0, 32'hFFAC0780);

    // Client 1 alone for 10 cycles, then client 0 joins.
    for (int i = 0; i < 14; i++) q1.push_back('{1'b1, AW'(30 + i), 32'($urandom)});
    glog.delete();
    drive_cycle();
    log_en = 1;
    repeat (9) drive_cycle();
    q0.push_back('{1'b0, 7'd30, 32'd0});
    run_until_idle(100);
    log_en = 0;
    for (int i = 0; i < 10; i++) check_value($sformatf("f_gnt%0d", i), glog[i], 2);
    check_value("f_gnt10", glog[10], 1);
    check_value("f_gnt11", glog[11], 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter_2ch.md
Name: ram_arbiter_2ch

Overview:
- Two-requester arbiter and sequencer in front of the single-port ram128x32 (Clk, Write_enable, Add, Data, Q).
- Multiplexes the read/write commands of two clients onto the RAM port.
- Arbitration is round-robin with a bounded burst hold per client.
- Returns read data to the issuing client with a fixed latency and a valid strobe.

Parameters:
ADD_WIDTH, 7, RAM address width (128 words)
DATA_WIDTH, 32, RAM data width
MAX_BURST, 4, max consecutive grants to one client while the other is requesting (>=1)

Ports:
Clk  input  1  clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Req0  input  1  client 0 command request
We0  input  1  client 0 write (1) / read (0)
Add0  input  ADD_WIDTH  client 0 address
Data0  input  DATA_WIDTH  client 0 write data
Gnt0  output  1  client 0 command accepted this cycle
Rvalid0  output  1  client 0 read data valid
Rdata0  output  DATA_WIDTH  client 0 read data
Req1/We1/Add1/Data1/Gnt1/Rvalid1/Rdata1  same as client 0, for client 1
Ram_we  output  1  to RAM Write_enable
Ram_add  output  ADD_WIDTH  to RAM Add
Ram_data  output  DATA_WIDTH  to RAM Data
Ram_q  input  DATA_WIDTH  from RAM Q

Behaviour:
- Clock and reset: one clock, Clk. Rst_n is asynchronous, active-low.
- RAM contract:
  - Write_enable, Add and Data are sampled on the Clk rising edge.
  - Q is registered and shows mem[Add] in the cycle after the sampling edge.
  - A read issued the cycle after a write to the same address returns the new data.
- Transfer rule: a command transfers in a cycle where Reqx=1 and Gntx=1.
  - Gntx is combinational from state and Req0/Req1.
  - At most one of Gnt0/Gnt1 is high in any cycle.
  - Add/Data/We of a client must be stable while its Req is high and Gnt is low.
- Command issue:
  - On a transfer in cycle N, Ram_we/Ram_add/Ram_data register the winner's We/Add/Data at the end of cycle N and drive the RAM in cycle N+1.
  - With no transfer, Ram_we=0 and Ram_add/Ram_data hold their last values.
- Read return:
  - A read transferred in cycle N produces Rvalidx=1 for exactly one cycle in N+2.
  - Rdatax=Ram_q in that cycle.
  - The channel tag is carried in a 2-stage valid/tag pipeline.
  - Rdatax holds its last value while Rvalidx=0.
  - Back-to-back reads give back-to-back Rvalid in issue order.
  - Writes produce no Rvalid.
- FSM states: IDLE, OWN0, OWN1. Registers: last-served pointer Last (reset 1, so client 0 has first priority) and burst counter Cnt.
- IDLE:
  - Only one client requesting: grant it, go to its OWN state, Cnt=1.
  - Both requesting: grant client !Last.
  - Neither requesting: stay in IDLE.
- OWNx:
  - Reqx=1 and (Req other=0 or Cnt<MAX_BURST): grant x, Cnt+1 saturating at MAX_BURST.
  - Reqx=1, Req other=1 and Cnt==MAX_BURST: grant the other client this cycle, go to OWN(other), Cnt=1, Last=x.
  - Reqx=0 and Req other=1: grant the other client, go to OWN(other), Cnt=1, Last=x.
  - Both low: go to IDLE, Last=x, no grant.
- No idle cycle between grants; a handoff costs no bubble.
- MAX_BURST=1 gives strict alternation under contention.
- Reset (asynchronous, any time):
  - State=IDLE, Last=1, Cnt=0.
  - Gnt0=Gnt1=0, Ram_we=0, Ram_add=0, Ram_data=0.
  - Rvalid0=Rvalid1=0, Rdata0=Rdata1=0.
  - Read-return pipeline flushed; reads in flight at reset never return Rvalid.
  - Gnt is forced 0 while Rst_n=0.
- Hazards:
  - Writes and reads from different clients to the same address complete in grant order.
  - A read granted after a write returns the written value.

Test Plan:
- Reset, then client 0 writes 32'd1 to addr 0, 32'd10 to 10, 32'd220 to 20 back-to-back -> Gnt0 high 3 consecutive cycles, Ram_we=1 with matching Ram_add/Ram_data one cycle after each grant, no Rvalid0.
- Client 0 reads addr 0,10,20 consecutively -> Rvalid0 in cycles N+2..N+4 with Rdata0 = 1, 10, 220.
- Both clients request continuously from IDLE with MAX_BURST=4 -> Gnt0 for cycles 1-4, Gnt1 for 5-8, Gnt0 for 9-12; no cycle with both or neither granted.
- Client 1 writes 32'hFFFFFFFF to addr 127 and client 0 reads addr 127 in the next granted slot -> Rvalid0 with Rdata0=32'hFFFFFFFF and Rvalid1 never asserted.
- Client 0 reads addr 100 (holding 32'hFFAC0780), then Rst_n pulses low asynchronously mid-cycle before the return -> all outputs 0 immediately, no Rvalid0 afterwards; after release, a re-read returns 32'hFFAC0780.
- Client 1 holds Req1 alone for 10 cycles, then Req0 rises -> Gnt1 continues until Cnt reaches MAX_BURST, then Gnt0 in the following cycle.
